// File: rtl/ping_pong_pkg.sv
// Shared types and defaults for the ping-pong counter controller.
package ping_pong_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int PP_WIDTH       = 4;
  localparam int PP_MAX_DEFAULT = 15;
  localparam int PP_MIN_DEFAULT = 0;

endpackage : ping_pong_pkg

// File: rtl/pp_one_pulse.sv
// Rising-edge detector: one registered single-cycle pulse per 0->1 input transition.
module pp_one_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic in_lvl,
  output logic pulse
);

  logic prev_q;
  logic pulse_q;
  logic pulse_d;

  always_comb begin
    pulse_d = in_lvl & ~prev_q;
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      prev_q  <= in_lvl;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule : pp_one_pulse

// File: rtl/ping_pong_ctrl.sv
// Run/flip sequencer and range configurator for the ping-pong counter.
// Optional turnaround counter enabled by defining BOUNCE_COUNT_EN.
module ping_pong_ctrl
  import ping_pong_pkg::*;
#(
  parameter int WIDTH       = PP_WIDTH,
  parameter int MAX_DEFAULT = PP_MAX_DEFAULT,
  parameter int MIN_DEFAULT = PP_MIN_DEFAULT,
  parameter int HOLD_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             flip_btn,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_max,
  input  logic [WIDTH-1:0] cfg_min,
  output logic             cfg_ready,
  output logic             cfg_err,
  input  logic             cnt_dir,
  output logic             cnt_enable,
  output logic             cnt_flip,
  output logic [WIDTH-1:0] cnt_max,
  output logic [WIDTH-1:0] cnt_min,
  output logic             busy,
  output logic [15:0]      bounce_cnt
);

  localparam int             HW        = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0]  HOLD_LOAD = HW'(HOLD_CYCLES - 1);

  state_e           state_q, state_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [WIDTH-1:0] max_q, max_d, min_q, min_d;
  logic             enable_q, enable_d;
  logic             flip_q, flip_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             flip_pulse;
  logic             accept, legal, accept_ok;

  pp_one_pulse u_flip_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_lvl (flip_btn),
    .pulse  (flip_pulse)
  );

  assign accept    = cfg_valid & ready_q;
  assign legal     = cfg_min < cfg_max;
  assign accept_ok = accept & legal;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    max_d   = max_q;
    min_d   = min_q;
    if (accept_ok) begin
      max_d = cfg_max;
      min_d = cfg_min;
    end
    case (state_q)
      IDLE: if (run) state_d = RUN;
      RUN: begin
        // A range change outranks both a run drop and a pending flip.
        if (accept_ok) begin
          state_d = HOLD;
          hold_d  = HOLD_LOAD;
        end else if (!run) begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (hold_q == '0) state_d = run ? RUN : IDLE;
        else              hold_d  = hold_q - HW'(1);
      end
      default: state_d = IDLE;
    endcase
    enable_d = (state_d == RUN);
    busy_d   = (state_d == HOLD);
    ready_d  = (state_d != HOLD);
    err_d    = accept & ~legal;
    flip_d   = flip_pulse & (state_q == RUN) & ~accept_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      max_q    <= WIDTH'(MAX_DEFAULT);
      min_q    <= WIDTH'(MIN_DEFAULT);
      enable_q <= 1'b0;
      flip_q   <= 1'b0;
      ready_q  <= 1'b1;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      max_q    <= max_d;
      min_q    <= min_d;
      enable_q <= enable_d;
      flip_q   <= flip_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

`ifdef BOUNCE_COUNT_EN
  logic        dir_q;
  logic [15:0] bounce_q, bounce_d;

  always_comb begin
    bounce_d = bounce_q;
    if (accept_ok && state_q == IDLE) begin
      bounce_d = '0;
    end else if (enable_q && (cnt_dir != dir_q) && (bounce_q != 16'hFFFF)) begin
      bounce_d = bounce_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q    <= 1'b1;
      bounce_q <= '0;
    end else begin
      dir_q    <= cnt_dir;
      bounce_q <= bounce_d;
    end
  end

  assign bounce_cnt = bounce_q;
`else
  logic unused_cnt_dir;
  assign unused_cnt_dir = cnt_dir;
  assign bounce_cnt     = '0;
`endif

  assign cfg_ready  = ready_q;
  assign cfg_err    = err_q;
  assign cnt_enable = enable_q;
  assign cnt_flip   = flip_q;
  assign cnt_max    = max_q;
  assign cnt_min    = min_q;
  assign busy       = busy_q;

endmodule : ping_pong_ctrl

// File: tb/tb_ping_pong_ctrl.sv
// Directed scoreboard bench for ping_pong_ctrl; bounce checks follow BOUNCE_COUNT_EN.
module tb_ping_pong_ctrl;

  typedef enum int {S_EN, S_FLIP, S_MAX, S_MIN, S_BUSY, S_RDY, S_ERR, S_BNC} sel_e;

  typedef struct {
    string       tag;
    sel_e        sel;
    logic [15:0] exp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run, flip_btn, cfg_valid, cnt_dir;
  logic [3:0]  cfg_max, cfg_min;
  logic        cfg_ready, cfg_err, cnt_enable, cnt_flip, busy;
  logic [3:0]  cnt_max, cnt_min;
  logic [15:0] bounce_cnt;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  logic [15:0] bexp;

  ping_pong_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .flip_btn   (flip_btn),
    .cfg_valid  (cfg_valid),
    .cfg_max    (cfg_max),
    .cfg_min    (cfg_min),
    .cfg_ready  (cfg_ready),
    .cfg_err    (cfg_err),
    .cnt_dir    (cnt_dir),
    .cnt_enable (cnt_enable),
    .cnt_flip   (cnt_flip),
    .cnt_max    (cnt_max),
    .cnt_min    (cnt_min),
    .busy       (busy),
    .bounce_cnt (bounce_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] observe(sel_e s);
    case (s)
      S_EN:    return {15'd0, cnt_enable};
      S_FLIP:  return {15'd0, cnt_flip};
      S_MAX:   return {12'd0, cnt_max};
      S_MIN:   return {12'd0, cnt_min};
      S_BUSY:  return {15'd0, busy};
      S_RDY:   return {15'd0, cfg_ready};
      S_ERR:   return {15'd0, cfg_err};
      default: return bounce_cnt;
    endcase
  endfunction

  task automatic push(input string tag, input sel_e s, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = s;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t        e;
    logic [15:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.sel);
      checks++;
      assert (o === e.exp) else begin
        failures++;
        $error("FAIL %s: observed=%0h expected=%0h", e.tag, o, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ctrl(input string tag, input logic en, input logic bz, input logic fl);
    push({tag, "_en"}, S_EN, {15'd0, en});
    push({tag, "_busy"}, S_BUSY, {15'd0, bz});
    push({tag, "_rdy"}, S_RDY, {15'd0, ~bz});
    push({tag, "_flip"}, S_FLIP, {15'd0, fl});
  endtask

  task automatic push_reset_vals(input string tag);
    push_ctrl(tag, 1'b0, 1'b0, 1'b0);
    push({tag, "_max"}, S_MAX, 16'd15);
    push({tag, "_min"}, S_MIN, 16'd0);
    push({tag, "_err"}, S_ERR, 16'd0);
    push({tag, "_bnc"}, S_BNC, 16'd0);
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; flip_btn = 1'b0; cfg_valid = 1'b0;
    cfg_max = 4'd0; cfg_min = 4'd0; cnt_dir = 1'b1;
    repeat (3) tick();
    push_reset_vals("reset");
    check();
    rst_n = 1'b1;
    tick();

    // Start: enable stays low in IDLE, rises one edge after run.
    run = 1'b1;
    push("idle_en", S_EN, 16'd0);
    check();
    tick();
    push_ctrl("run", 1'b1, 1'b0, 1'b0);
    push("run_max", S_MAX, 16'd15);
    push("run_min", S_MIN, 16'd0);
    check();

    // Legal range in RUN: update at accept edge, two HOLD cycles, then RUN.
    cfg_valid = 1'b1; cfg_max = 4'd12; cfg_min = 4'd5;
    tick();
    cfg_valid = 1'b0;
    push_ctrl("hold1", 1'b0, 1'b1, 1'b0);
    push("hold1_max", S_MAX, 16'd12);
    push("hold1_min", S_MIN, 16'd5);
    check();
    tick();
    push_ctrl("hold2", 1'b0, 1'b1, 1'b0);
    check();
    tick();
    push_ctrl("hold_exit", 1'b1, 1'b0, 1'b0);
    check();

    // Illegal range (min == max): error pulse only.
    cfg_valid = 1'b1; cfg_max = 4'd3; cfg_min = 4'd3;
    tick();
    cfg_valid = 1'b0;
    push("err_pulse", S_ERR, 16'd1);
    push("err_max", S_MAX, 16'd12);
    push("err_min", S_MIN, 16'd5);
    push_ctrl("err", 1'b1, 1'b0, 1'b0);
    check();
    tick();
    push("err_clear", S_ERR, 16'd0);
    push("err_nohold", S_BUSY, 16'd0);
    check();

    // Flip held 5 cycles in RUN: one pulse, two edges after the rise.
    flip_btn = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      push($sformatf("flip_c%0d", i), S_FLIP, (i == 2) ? 16'd1 : 16'd0);
      check();
    end
    flip_btn = 1'b0;
    tick();
    push("flip_after", S_FLIP, 16'd0);
    check();

    // Flip rising during HOLD is discarded.
    cfg_valid = 1'b1; cfg_max = 4'd10; cfg_min = 4'd2;
    tick();
    cfg_valid = 1'b0; flip_btn = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      push($sformatf("hflip_c%0d", i), S_FLIP, 16'd0);
      check();
    end
    flip_btn = 1'b0;
    tick();

    // Legal cfg and flip edge together: range wins; run drop exits at HOLD end.
    cfg_valid = 1'b1; cfg_max = 4'd14; cfg_min = 4'd1; flip_btn = 1'b1;
    tick();
    cfg_valid = 1'b0; run = 1'b0;
    push_ctrl("both1", 1'b0, 1'b1, 1'b0);
    push("both_max", S_MAX, 16'd14);
    push("both_min", S_MIN, 16'd1);
    check();
    tick();
    push_ctrl("both2", 1'b0, 1'b1, 1'b0);
    check();
    tick();
    push_ctrl("both_idle", 1'b0, 1'b0, 1'b0);
    check();
    tick();
    flip_btn = 1'b0;
    push_ctrl("both_idle2", 1'b0, 1'b0, 1'b0);
    check();

    // Bounce counting: IDLE accept clears, then count direction changes in RUN.
    cfg_valid = 1'b1; cfg_max = 4'd15; cfg_min = 4'd1;
    tick();
    cfg_valid = 1'b0; run = 1'b1;
    bexp = 16'd0;
    push("bnc_clr", S_BNC, bexp);
    push("bnc_idle_busy", S_BUSY, 16'd0);
    push("bnc_min", S_MIN, 16'd1);
    check();
    tick();
    push("bnc_en", S_EN, 16'd1);
    check();
    for (int i = 0; i < 6; i++) begin
      if (i != 2) cnt_dir = ~cnt_dir;
      tick();
`ifdef BOUNCE_COUNT_EN
      if (i != 2) bexp = bexp + 16'd1;
`endif
      push($sformatf("bnc_step%0d", i), S_BNC, bexp);
      check();
    end

    // Reset in the middle of HOLD with a flip pending.
    cfg_valid = 1'b1; cfg_max = 4'd9; cfg_min = 4'd3; flip_btn = 1'b0;
    tick();
    cfg_valid = 1'b0; flip_btn = 1'b1;
    push("pre_rst_busy", S_BUSY, 16'd1);
    check();
    #2;
    rst_n = 1'b0; run = 1'b0;
    #1;
    push_reset_vals("midhold_rst");
    check();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    push("post_rst_flip", S_FLIP, 16'd0);
    push("post_rst_en", S_EN, 16'd0);
    check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_ping_pong_ctrl
